// File: rtl/tile_write_scheduler_if.sv
// Handshake between the frame scheduler and the tile writer: the tile start
// address, line stride and start pulse go out, and the writer's busy flag comes back.
interface tile_write_scheduler_if;
  logic [31:0] wr_addr;
  logic [15:0] wr_stride;
  logic        wr_start;
  logic        wr_running;

  modport master (output wr_addr, output wr_stride, output wr_start, input wr_running);
  modport slave  (input wr_addr, input wr_stride, input wr_start, output wr_running);
endinterface

// File: rtl/tile_write_scheduler.sv
// Frame-level sequencer: walks the tile grid in raster order and issues one writer job
// per tile. An abort lets the tile in flight finish, then ends the frame.
//
// state       | meaning
// IDLE        | waiting for frame_start
// ISSUE       | wr_start asserted for the current tile
// WAIT_ACCEPT | waiting for the writer to report running
// WAIT_DONE   | tile in flight; waiting for running to drop
// FINISH      | frame_done pulse
module tile_write_scheduler #(
  parameter int TILE_ROW_BYTES = 64,
  parameter int TILE_ROWS      = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [31:0]                     fb_base,
  input  logic [15:0]                     fb_stride,
  input  logic [7:0]                      tiles_x,
  input  logic [7:0]                      tiles_y,
  input  logic                            frame_start,
  input  logic                            abort,
  output logic                            frame_busy,
  output logic                            frame_done,
  output logic                            frame_aborted,
  output logic [15:0]                     tiles_done,
  tile_write_scheduler_if.master          wr
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_ACCEPT = 3'd2,
    WAIT_DONE   = 3'd3,
    FINISH      = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cfg_stride, cfg_stride_nxt;
  logic [7:0]  cfg_tx, cfg_tx_nxt;
  logic [7:0]  cfg_ty, cfg_ty_nxt;
  logic [7:0]  tx, tx_nxt;
  logic [7:0]  ty, ty_nxt;
  logic [31:0] row_base, row_base_nxt;
  logic [31:0] addr, addr_nxt;
  logic        abort_flag, abort_flag_nxt;
  logic        frame_busy_nxt, frame_done_nxt, frame_aborted_nxt;
  logic [15:0] tiles_done_nxt;
  logic [31:0] wr_addr_nxt;
  logic [15:0] wr_stride_nxt;
  logic        wr_start_nxt;
  logic [31:0] row_step;
  logic        last_x, last_y;

  assign row_step = {16'd0, cfg_stride} * 32'(TILE_ROWS);
  assign last_x   = (tx == cfg_tx - 8'd1);
  assign last_y   = (ty == cfg_ty - 8'd1);

  always_comb begin
    state_nxt         = state;
    cfg_stride_nxt    = cfg_stride;
    cfg_tx_nxt        = cfg_tx;
    cfg_ty_nxt        = cfg_ty;
    tx_nxt            = tx;
    ty_nxt            = ty;
    row_base_nxt      = row_base;
    addr_nxt          = addr;
    abort_flag_nxt    = abort_flag;
    frame_aborted_nxt = frame_aborted;
    tiles_done_nxt    = tiles_done;
    wr_addr_nxt       = wr.wr_addr;
    wr_stride_nxt     = wr.wr_stride;
    wr_start_nxt      = 1'b0;

    // Abort is only remembered while a frame is active; IDLE and FINISH ignore it.
    if (abort && (state == ISSUE || state == WAIT_ACCEPT || state == WAIT_DONE))
      abort_flag_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (frame_start) begin
          cfg_stride_nxt    = fb_stride;
          cfg_tx_nxt        = tiles_x;
          cfg_ty_nxt        = tiles_y;
          tx_nxt            = 8'd0;
          ty_nxt            = 8'd0;
          row_base_nxt      = fb_base;
          addr_nxt          = fb_base;
          tiles_done_nxt    = 16'd0;
          frame_aborted_nxt = 1'b0;
          abort_flag_nxt    = 1'b0;
          if (tiles_x == 8'd0 || tiles_y == 8'd0) begin
            state_nxt = FINISH;
          end else begin
            state_nxt     = ISSUE;
            wr_start_nxt  = 1'b1;
            wr_addr_nxt   = fb_base;
            wr_stride_nxt = fb_stride;
          end
        end
      end
      ISSUE: state_nxt = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (wr.wr_running) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!wr.wr_running) begin
          tiles_done_nxt = tiles_done + 16'd1;
          if (last_x && last_y) begin
            state_nxt = FINISH;
          end else if (abort_flag_nxt) begin
            state_nxt         = FINISH;
            frame_aborted_nxt = 1'b1;
          end else begin
            if (!last_x) begin
              tx_nxt   = tx + 8'd1;
              addr_nxt = addr + 32'(TILE_ROW_BYTES);
            end else begin
              tx_nxt       = 8'd0;
              ty_nxt       = ty + 8'd1;
              row_base_nxt = row_base + row_step;
              addr_nxt     = row_base + row_step;
            end
            state_nxt     = ISSUE;
            wr_start_nxt  = 1'b1;
            wr_addr_nxt   = addr_nxt;
            wr_stride_nxt = cfg_stride;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    frame_busy_nxt = (state_nxt == ISSUE) || (state_nxt == WAIT_ACCEPT) ||
                     (state_nxt == WAIT_DONE);
    frame_done_nxt = (state_nxt == FINISH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cfg_stride    <= 16'd0;
      cfg_tx        <= 8'd0;
      cfg_ty        <= 8'd0;
      tx            <= 8'd0;
      ty            <= 8'd0;
      row_base      <= 32'd0;
      addr          <= 32'd0;
      abort_flag    <= 1'b0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
      tiles_done    <= 16'd0;
      wr.wr_addr    <= 32'd0;
      wr.wr_stride  <= 16'd0;
      wr.wr_start   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cfg_stride    <= cfg_stride_nxt;
      cfg_tx        <= cfg_tx_nxt;
      cfg_ty        <= cfg_ty_nxt;
      tx            <= tx_nxt;
      ty            <= ty_nxt;
      row_base      <= row_base_nxt;
      addr          <= addr_nxt;
      abort_flag    <= abort_flag_nxt;
      frame_busy    <= frame_busy_nxt;
      frame_done    <= frame_done_nxt;
      frame_aborted <= frame_aborted_nxt;
      tiles_done    <= tiles_done_nxt;
      wr.wr_addr    <= wr_addr_nxt;
      wr.wr_stride  <= wr_stride_nxt;
      wr.wr_start   <= wr_start_nxt;
    end
  end

endmodule
